// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus between the ALU/load sources and the register-file write port.
// master = sources + register file side, slave = the arbiter.
interface regfile_writeback_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic                   register_write;
    logic [ADDR_W-1:0]      write_register;
    logic [DATA_W-1:0]      write_data;
    logic [2**ADDR_W-1:0]   pending_mask;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  register_write, write_register, write_data, pending_mask
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output register_write, write_register, write_data, pending_mask
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port; mem > alu unless WB_ROUND_ROBIN_EN.
// Accept-to-output is one edge when uncontested; each source stalls only when its own FIFO holds DEPTH entries.
module regfile_writeback_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    regfile_writeback_arbiter_if.slave   wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**ADDR_W;
    localparam int ALU   = 0;
    localparam int MEM   = 1;

    logic              in_vld [2];
    logic [ADDR_W-1:0] in_rd  [2];
    logic [DATA_W-1:0] in_dat [2];
    logic [1:0]        in_rdy;
    logic [1:0]        push;
    logic [1:0]        nonempty;
    logic [1:0]        gnt;

    logic [ADDR_W-1:0] rd_mem_q  [2][DEPTH];
    logic [DATA_W-1:0] dat_mem_q [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];

    logic              register_write_q;
    logic [ADDR_W-1:0] write_register_q;
    logic [DATA_W-1:0] write_data_q;

    logic              grant_vld;
    logic              sel;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_dat;
    logic [NREG-1:0]   pend_mask;
    logic [PTR_W-1:0]  off;

    assign in_vld[ALU] = wb.alu_valid;
    assign in_rd[ALU]  = wb.alu_rd;
    assign in_dat[ALU] = wb.alu_data;
    assign in_vld[MEM] = wb.mem_valid;
    assign in_rd[MEM]  = wb.mem_rd;
    assign in_dat[MEM] = wb.mem_data;

    // Ready comes from the registered count only, so a same-cycle pop never opens a slot.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            in_rdy[s]   = (cnt_q[s] < CNT_W'(DEPTH));
            nonempty[s] = (cnt_q[s] != '0);
            push[s]     = in_vld[s] && in_rdy[s];
        end
    end

`ifdef WB_ROUND_ROBIN_EN
    logic rr_mem_q;

    always_comb begin
        gnt      = '0;
        gnt[MEM] = nonempty[MEM] && (!nonempty[ALU] || rr_mem_q);
        gnt[ALU] = nonempty[ALU] && !gnt[MEM];
    end

    // Only a contested grant hands priority to the other source.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_mem_q <= 1'b1;
        end else if (nonempty[MEM] && nonempty[ALU]) begin
            rr_mem_q <= !rr_mem_q;
        end
    end
`else
    always_comb begin
        gnt      = '0;
        gnt[MEM] = nonempty[MEM];
        gnt[ALU] = nonempty[ALU] && !nonempty[MEM];
    end
`endif

    assign grant_vld = gnt[ALU] || gnt[MEM];
    assign sel       = gnt[MEM];
    assign head_rd   = rd_mem_q[sel][rd_ptr_q[sel]];
    assign head_dat  = dat_mem_q[sel][rd_ptr_q[sel]];

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(push[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(gnt[s]);
            cnt_d[s]    = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(gnt[s]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                cnt_q[s]    <= cnt_d[s];
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clock) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                rd_mem_q[s][wr_ptr_q[s]]  <= in_rd[s];
                dat_mem_q[s][wr_ptr_q[s]] <= in_dat[s];
            end
        end
    end

    // x0 writes are consumed but never enable the register file.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            register_write_q <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
        end else begin
            register_write_q <= grant_vld && (head_rd != '0);
            if (grant_vld) begin
                write_register_q <= head_rd;
                write_data_q     <= head_dat;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        pend_mask = '0;
        off       = '0;
        for (int s = 0; s < 2; s++) begin
            for (int e = 0; e < DEPTH; e++) begin
                off = PTR_W'(e) - rd_ptr_q[s];
                if ({1'b0, off} < cnt_q[s]) begin
                    pend_mask[rd_mem_q[s][e]] = 1'b1;
                end
            end
        end
        if (register_write_q) begin
            pend_mask[write_register_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign wb.alu_ready      = in_rdy[ALU];
    assign wb.mem_ready      = in_rdy[MEM];
    assign wb.register_write = register_write_q;
    assign wb.write_register = write_register_q;
    assign wb.write_data     = write_data_q;
    assign wb.pending_mask   = pend_mask;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: per-scenario tasks with hand-computed expectations.
module tb_regfile_writeback_arbiter;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic clock = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    regfile_writeback_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    regfile_writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .wb    (wb)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
        wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #12;
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_out: got rw=%0b rd=%0d data=%h, want all 0", wb.register_write, wb.write_register, wb.write_data);
        end
        vectors++;
        if (wb.pending_mask !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_pending: got %h want 00000000", wb.pending_mask);
        end
        vectors++;
        if ({wb.alu_ready, wb.mem_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 11", {wb.alu_ready, wb.mem_ready});
        end
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (wb.register_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_rw: got %0b want 0", wb.register_write);
        end
    endtask

    task automatic test_single_alu();
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'h1234;
        tick();
        idle_inputs();
        vectors++;
        if ({wb.register_write, wb.pending_mask} !== {1'b0, 32'h20}) begin
            miscompares++;
            $display("FAIL single_e1: got rw=%0b pend=%h want rw=0 pend=00000020", wb.register_write, wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data} !== {1'b1, 5'd5, 32'h1234}) begin
            miscompares++;
            $display("FAIL single_out: got rw=%0b rd=%0d data=%h want rw=1 rd=5 data=00001234", wb.register_write, wb.write_register, wb.write_data);
        end
        vectors++;
        if (wb.pending_mask !== 32'h20) begin
            miscompares++;
            $display("FAIL single_pend_e2: got %h want 00000020", wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.pending_mask} !== {1'b0, 5'd5, 32'h0}) begin
            miscompares++;
            $display("FAIL single_e3: got rw=%0b rd=%0d pend=%h want rw=0 rd=5 pend=0", wb.register_write, wb.write_register, wb.pending_mask);
        end
    endtask

    task automatic test_contested();
        logic [ADDR_W-1:0] r1, r2;
        logic [DATA_W-1:0] d1, d2;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'hA;
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd4; wb.mem_data = 32'hB;
        tick();
        idle_inputs();
        vectors++;
        if (wb.pending_mask !== 32'h18) begin
            miscompares++;
            $display("FAIL contest_pend_e1: got %h want 00000018", wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data, wb.pending_mask} !== {1'b1, 5'd4, 32'hB, 32'h18}) begin
            miscompares++;
            $display("FAIL contest_first: got rw=%0b rd=%0d data=%h pend=%h want 1/4/0000000b/00000018", wb.register_write, wb.write_register, wb.write_data, wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data, wb.pending_mask} !== {1'b1, 5'd3, 32'hA, 32'h08}) begin
            miscompares++;
            $display("FAIL contest_second: got rw=%0b rd=%0d data=%h pend=%h want 1/3/0000000a/00000008", wb.register_write, wb.write_register, wb.write_data, wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.pending_mask} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL contest_idle: got rw=%0b pend=%h want 0/0", wb.register_write, wb.pending_mask);
        end
`ifdef WB_ROUND_ROBIN_EN
        r1 = 5'd6; d1 = 32'hC; r2 = 5'd7; d2 = 32'hD;
`else
        r1 = 5'd7; d1 = 32'hD; r2 = 5'd6; d2 = 32'hC;
`endif
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd6; wb.alu_data = 32'hC;
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd7; wb.mem_data = 32'hD;
        tick();
        idle_inputs();
        vectors++;
        if (wb.pending_mask !== 32'hC0) begin
            miscompares++;
            $display("FAIL contest2_pend: got %h want 000000c0", wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data} !== {1'b1, r1, d1}) begin
            miscompares++;
            $display("FAIL contest2_first: got rw=%0b rd=%0d data=%h want rw=1 rd=%0d data=%h", wb.register_write, wb.write_register, wb.write_data, r1, d1);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data} !== {1'b1, r2, d2}) begin
            miscompares++;
            $display("FAIL contest2_second: got rw=%0b rd=%0d data=%h want rw=1 rd=%0d data=%h", wb.register_write, wb.write_register, wb.write_data, r2, d2);
        end
        tick();
    endtask

    task automatic test_x0();
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        vectors++;
        if ({wb.alu_ready, wb.pending_mask} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL x0_accept: got ready=%0b pend=%h want 1/0", wb.alu_ready, wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data, wb.pending_mask} !== {1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0}) begin
            miscompares++;
            $display("FAIL x0_out: got rw=%0b rd=%0d data=%h pend=%h want 0/0/ffffffff/0", wb.register_write, wb.write_register, wb.write_data, wb.pending_mask);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] er;
        logic [DATA_W-1:0] ed;
        logic [31:0]       ep;
        for (int i = 1; i <= 8; i++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = 5'(i); wb.alu_data = 32'hBB00 + 32'(i);
            tick();
            vectors++;
            if (wb.alu_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready_%0d: got %0b want 1", i, wb.alu_ready);
            end
            if (i >= 2) begin
                er = 5'(i - 1);
                ed = 32'hBB00 + 32'(i - 1);
                ep = (32'd1 << i) | (32'd1 << (i - 1));
                vectors++;
                if ({wb.register_write, wb.write_register, wb.write_data, wb.pending_mask} !== {1'b1, er, ed, ep}) begin
                    miscompares++;
                    $display("FAIL b2b_out_%0d: got rw=%0b rd=%0d data=%h pend=%h want 1/%0d/%h/%h", i, wb.register_write, wb.write_register, wb.write_data, wb.pending_mask, er, ed, ep);
                end
            end
        end
        idle_inputs();
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data, wb.pending_mask} !== {1'b1, 5'd8, 32'hBB08, 32'h100}) begin
            miscompares++;
            $display("FAIL b2b_last: got rw=%0b rd=%0d data=%h pend=%h want 1/8/0000bb08/00000100", wb.register_write, wb.write_register, wb.write_data, wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.pending_mask} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL b2b_idle: got rw=%0b pend=%h want 0/0", wb.register_write, wb.pending_mask);
        end
    endtask

    task automatic test_starvation();
        logic [ADDR_W-1:0] er;
        logic [DATA_W-1:0] ed;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd1; wb.alu_data = 32'h100;
        wb.mem_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wb.mem_rd = 5'(16 + k); wb.mem_data = 32'h5000 + 32'(k);
            tick();
            if (k == 0) begin
                wb.alu_rd = 5'd2; wb.alu_data = 32'h200;
            end else begin
                if (k == 1) begin
                    wb.alu_rd = 5'd3; wb.alu_data = 32'h300;
                end
                vectors++;
                if (wb.alu_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL starve_ready_%0d: got %0b want 0", k, wb.alu_ready);
                end
                er = 5'(16 + k - 1);
                ed = 32'h5000 + 32'(k - 1);
                vectors++;
                if ({wb.register_write, wb.write_register, wb.write_data} !== {1'b1, er, ed}) begin
                    miscompares++;
                    $display("FAIL starve_mem_%0d: got rw=%0b rd=%0d data=%h want 1/%0d/%h", k, wb.register_write, wb.write_register, wb.write_data, er, ed);
                end
            end
        end
        idle_inputs();
        tick();
        vectors++;
        if ({wb.alu_ready, wb.register_write, wb.write_register, wb.write_data, wb.pending_mask} !== {1'b0, 1'b1, 5'd20, 32'h5004, 32'h0010_0006}) begin
            miscompares++;
            $display("FAIL starve_last_mem: got ready=%0b rw=%0b rd=%0d data=%h pend=%h want 0/1/20/00005004/00100006", wb.alu_ready, wb.register_write, wb.write_register, wb.write_data, wb.pending_mask);
        end
        tick();
        vectors++;
        if ({wb.alu_ready, wb.register_write, wb.write_register, wb.write_data} !== {1'b1, 1'b1, 5'd1, 32'h100}) begin
            miscompares++;
            $display("FAIL starve_alu0: got ready=%0b rw=%0b rd=%0d data=%h want 1/1/1/00000100", wb.alu_ready, wb.register_write, wb.write_register, wb.write_data);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data} !== {1'b1, 5'd2, 32'h200}) begin
            miscompares++;
            $display("FAIL starve_alu1: got rw=%0b rd=%0d data=%h want 1/2/00000200", wb.register_write, wb.write_register, wb.write_data);
        end
        tick();
        vectors++;
        if ({wb.register_write, wb.pending_mask} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL starve_idle: got rw=%0b pend=%h want 0/0", wb.register_write, wb.pending_mask);
        end
    endtask

    task automatic test_reset_mid();
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd9;  wb.alu_data = 32'h900;
        wb.mem_valid = 1'b1; wb.mem_rd = 5'd12; wb.mem_data = 32'hC00;
        tick();
        wb.alu_rd = 5'd10; wb.alu_data = 32'hA00;
        wb.mem_rd = 5'd13; wb.mem_data = 32'hD00;
        tick();
        idle_inputs();
        vectors++;
        if ({wb.alu_ready, wb.register_write, wb.write_register, wb.pending_mask} !== {1'b0, 1'b1, 5'd12, 32'h3600}) begin
            miscompares++;
            $display("FAIL mid_loaded: got ready=%0b rw=%0b rd=%0d pend=%h want 0/1/12/00003600", wb.alu_ready, wb.register_write, wb.write_register, wb.pending_mask);
        end
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({wb.register_write, wb.write_register, wb.write_data, wb.pending_mask, wb.alu_ready, wb.mem_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL mid_reset: got rw=%0b rd=%0d data=%h pend=%h rdy=%b want 0/0/0/0/11", wb.register_write, wb.write_register, wb.write_data, wb.pending_mask, {wb.alu_ready, wb.mem_ready});
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if ({wb.register_write, wb.write_register, wb.pending_mask, wb.alu_ready, wb.mem_ready} !== {1'b0, 5'd0, 32'd0, 2'b11}) begin
                miscompares++;
                $display("FAIL mid_after_%0d: got rw=%0b rd=%0d pend=%h rdy=%b want 0/0/0/11", c, wb.register_write, wb.write_register, wb.pending_mask, {wb.alu_ready, wb.mem_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_contested();
        test_x0();
        test_back_to_back();
`ifndef WB_ROUND_ROBIN_EN
        test_starvation();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
